// File: rtl/ex_hazard_sequencer.sv
// Execute-stage hazard control: operand forwarding, load-use and branch stall/flush
// generation, multi-cycle op sequencing, and saturating stall/flush event counters.
module ex_hazard_sequencer #(
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RS1E,
    input  logic [4:0]       RS2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MultiE,
    input  logic             CntClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleM,
    output logic             MultiBusy,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MULTI_LAT - 2);

    state_t           stateReg, stateNext;
    logic [3:0]       cntReg, cntNext;
    logic             mstall;
    logic             lwStall;
    logic [CNT_W-1:0] stallCntReg, flushCntReg;
    logic [9:0]       rsE;
    logic [3:0]       fwdSel;

    assign rsE = {RS2E, RS1E};

    // Memory stage beats writeback so the youngest value of a register wins.
    for (genvar gi = 0; gi < 2; gi++) begin : gFwd
        assign fwdSel[2*gi +: 2] =
            (RegWriteM && (RdM != 5'd0) && (RdM == rsE[5*gi +: 5])) ? 2'b10 :
            (RegWriteW && (RdW != 5'd0) && (RdW == rsE[5*gi +: 5])) ? 2'b01 : 2'b00;
    end

    assign ForwardAE = fwdSel[1:0];
    assign ForwardBE = fwdSel[3:2];

    assign lwStall = ResultSrcE && (RdE != 5'd0) && ((RdE == RS1D) || (RdE == RS2D));

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        mstall    = 1'b0;
        if (rst) begin
            case (stateReg)
                IDLE: begin
                    // A taken branch flushes the op, so no sequence may start.
                    if (MultiE && !PCSrcE) begin
                        mstall    = 1'b1;
                        stateNext = BUSY;
                        cntNext   = CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cntReg != 4'd0) begin
                        mstall  = 1'b1;
                        cntNext = cntReg - 4'd1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
            cntReg   <= 4'd0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    assign StallF    = lwStall | mstall;
    assign StallD    = lwStall | mstall;
    assign StallE    = mstall;
    assign BubbleM   = mstall;
    assign FlushD    = PCSrcE;
    // Never flush D/E while it holds a multi-cycle op.
    assign FlushE    = PCSrcE | (lwStall & ~mstall);
    assign MultiBusy = (stateReg == BUSY);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stallCntReg <= '0;
            flushCntReg <= '0;
        end else if (CntClr) begin
            stallCntReg <= '0;
            flushCntReg <= '0;
        end else begin
            if (StallF && !(&stallCntReg))
                stallCntReg <= stallCntReg + CNT_W'(1);
            if (PCSrcE && !(&flushCntReg))
                flushCntReg <= flushCntReg + CNT_W'(1);
        end
    end

    assign StallCnt = stallCntReg;
    assign FlushCnt = flushCntReg;

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Bench for ex_hazard_sequencer: vector table, hand-written multi-cycle/reset/saturation
// sequences and random stimulus, all checked against a cycle-level behavioural model.
module tb_ex_hazard_sequencer;

    localparam int LAT  = 4;
    localparam int CW   = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    RS1D, RS2D, RS1E, RS2E, RdE, RdM, RdW;
    logic          ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MultiE, CntClr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, FlushD, FlushE, BubbleM, MultiBusy;
    logic [CW-1:0] StallCnt, FlushCnt;

    ex_hazard_sequencer #(.MULTI_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MultiE(MultiE), .CntClr(CntClr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM), .MultiBusy(MultiBusy),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Model: busyLeft counts execute-occupancy cycles still owed by a multi-cycle op.
    int   busyLeft = 0;
    int   mSc = 0;
    int   mFc = 0;
    logic mStallF;
    logic doCheck = 1'b1;
    // Snapshot: {FA[10:9], FB[8:7], StallF, StallD, StallE, FlushD, FlushE, BubbleM, MultiBusy}
    logic [10:0] sOut;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       ld, rwm, rww, br;
        logic [1:0] fa, fb;
        logic       stall, flushD, flushE;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(int rs1d, int rs2d, int rs1e, int rs2e, int rde, int rdm,
                                int rdw, int ld, int rwm, int rww, int br, int fa, int fb,
                                int st, int fd, int fe);
        vec_t v;
        v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
        v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
        v.ld = 1'(ld); v.rwm = 1'(rwm); v.rww = 1'(rww); v.br = 1'(br);
        v.fa = 2'(fa); v.fb = 2'(fb); v.stall = 1'(st); v.flushD = 1'(fd); v.flushE = 1'(fe);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdOf(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clearIns();
        {RS1D, RS2D, RS1E, RS2E, RdE, RdM, RdW} = '0;
        {ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MultiE, CntClr} = '0;
    endtask

    // Inputs are set at a rising edge; outputs are sampled 1 ns later, the model
    // advances on the falling edge, and the task returns on the next rising edge.
    task automatic cycle();
        logic lw, ms;
        logic [10:0] expOut;
        #1;
        if (!rst) begin
            busyLeft = 0; mSc = 0; mFc = 0;
        end
        lw = ResultSrcE && RdE != 0 && (RdE == RS1D || RdE == RS2D);
        ms = rst && (busyLeft > 1 || (busyLeft == 0 && MultiE && !PCSrcE));
        mStallF = lw | ms;
        expOut = {fwdOf(RS1E), fwdOf(RS2E), lw | ms, lw | ms, ms, PCSrcE,
                  PCSrcE | (lw & ~ms), ms, 1'(busyLeft > 0)};
        sOut = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, BubbleM, MultiBusy};
        if (doCheck) begin
            chk("outputs", 32'(sOut), 32'(expOut));
            chk("StallCnt", 32'(StallCnt), 32'(mSc));
            chk("FlushCnt", 32'(FlushCnt), 32'(mFc));
        end
        @(negedge clk);
        if (rst) begin
            if (CntClr) begin
                mSc = 0; mFc = 0;
            end else begin
                if (mStallF) mSc = (mSc < MAXC) ? mSc + 1 : MAXC;
                if (PCSrcE)  mFc = (mFc < MAXC) ? mFc + 1 : MAXC;
            end
            if (busyLeft > 0) busyLeft--;
            else if (MultiE && !PCSrcE) busyLeft = LAT - 1;
        end
        @(posedge clk);
    endtask

    // Pulses MultiE and checks stall/busy windows against fixed expectations.
    task automatic multiSeq(input string tag, input logic withLw);
        for (int k = 0; k <= LAT; k++) begin
            clearIns();
            MultiE = (k == 0);
            if (withLw && k > 0) begin
                ResultSrcE = 1'b1; RdE = 5'd7; RS1D = 5'd7;
            end
            cycle();
            chk($sformatf("%s_StallE_k%0d", tag, k), 32'(sOut[4]), 32'(k < LAT - 1));
            chk($sformatf("%s_Busy_k%0d", tag, k), 32'(sOut[0]), 32'(k >= 1 && k <= LAT - 1));
            if (withLw && k > 0 && k < LAT - 1)
                chk($sformatf("%s_FlushE_k%0d", tag, k), 32'(sOut[2]), 32'd0);
        end
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 2, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 3, 9, 0, 3, 9, 0, 1, 1, 0, 2, 1, 0, 0, 0);
        tbl[5]  = mk(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[9]  = mk(7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1);
        tbl[10] = mk(0, 0, 0, 5, 0, 5, 5, 0, 1, 1, 0, 0, 2, 0, 0, 0);

        rst = 1'b0;
        clearIns();
        @(posedge clk);
        cycle();
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            clearIns();
            RS1D = tbl[i].rs1d; RS2D = tbl[i].rs2d; RS1E = tbl[i].rs1e; RS2E = tbl[i].rs2e;
            RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
            ResultSrcE = tbl[i].ld; RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww;
            PCSrcE = tbl[i].br;
            cycle();
            chk($sformatf("vec%0d", i), 32'({sOut[10:7], sOut[6], sOut[4], sOut[3], sOut[2]}),
                32'({tbl[i].fa, tbl[i].fb, tbl[i].stall, 1'b0, tbl[i].flushD, tbl[i].flushE}));
        end

        // Branch and multi-cycle together: the flush wins, no sequence starts.
        clearIns();
        PCSrcE = 1'b1; MultiE = 1'b1;
        cycle();
        chk("brMulti_StallE", 32'(sOut[4]), 32'd0);
        clearIns();
        cycle();
        chk("brMulti_Busy", 32'(sOut[0]), 32'd0);

        multiSeq("multi", 1'b0);
        multiSeq("multiLw", 1'b1);

        // Asynchronous reset while BUSY with one stall cycle still pending.
        clearIns();
        MultiE = 1'b1;
        cycle();
        clearIns();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rstBusy", 32'({sOut[6], sOut[4], sOut[0]}), 32'd0);
        chk("rstStallCnt", 32'(StallCnt), 32'd0);
        chk("rstFlushCnt", 32'(FlushCnt), 32'd0);
        rst = 1'b1;
        cycle();
        multiSeq("afterRst", 1'b0);

        // Random traffic over a small register set so hazards collide often.
        for (int i = 0; i < 1500; i++) begin
            RS1D = 5'($urandom_range(0, 3)); RS2D = 5'($urandom_range(0, 3));
            RS1E = 5'($urandom_range(0, 3)); RS2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 1'($urandom_range(0, 1));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE = ($urandom_range(0, 7) == 0);
            MultiE = ($urandom_range(0, 3) == 0);
            CntClr = ($urandom_range(0, 31) == 0);
            rst    = ($urandom_range(0, 63) != 0);
            cycle();
        end
        rst = 1'b1;

        // Saturation: hold a load-use stall well past the counter range.
        clearIns();
        CntClr = 1'b1;
        cycle();
        clearIns();
        ResultSrcE = 1'b1; RdE = 5'd7; RS2D = 5'd7;
        doCheck = 1'b0;
        repeat ((1 << CW) + 3) cycle();
        doCheck = 1'b1;
        #1;
        chk("StallCnt_sat", 32'(StallCnt), 32'(MAXC));
        CntClr = 1'b1;
        cycle();
        #1;
        chk("StallCnt_clr", 32'(StallCnt), 32'd0);
        chk("FlushCnt_clr", 32'(FlushCnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ex_hazard_sequencer.md
Name: ex_hazard_sequencer

Overview:
Pipeline control block for the 5-stage core.
- Generates the forwarding selects for the execute-stage ALU operands.
- Detects load-use hazards and converts branch-taken into fetch/decode/execute stall and flush controls.
- Sequences multi-cycle execute operations that hold the shared ALU for several cycles.
- Maintains saturating stall and flush event counters for performance debug.

Parameters:
MULTI_LAT, 4, total cycles a multi-cycle op occupies the execute stage; legal range 2..16.
CNT_W, 16, width of the stall and flush event counters.

Ports:
clk  input  1  pipeline clock; state updates on the falling edge, the same edge as the pipeline registers.
rst  input  1  asynchronous, active-low reset.
RS1D  input  5  rs1 of the instruction in decode.
RS2D  input  5  rs2 of the instruction in decode.
RS1E  input  5  rs1 of the instruction in execute.
RS2E  input  5  rs2 of the instruction in execute.
RdE  input  5  destination register in execute.
RdM  input  5  destination register in memory.
RdW  input  5  destination register in writeback.
ResultSrcE  input  1  1 = the instruction in execute is a load.
RegWriteM  input  1  the memory-stage instruction writes the register file.
RegWriteW  input  1  the writeback-stage instruction writes the register file.
PCSrcE  input  1  branch taken, resolved in execute.
MultiE  input  1  the execute-stage instruction is a multi-cycle op.
CntClr  input  1  synchronous clear of both counters.
ForwardAE  output  2  operand A select: 00 = RD1E, 01 = writeback result, 10 = ALUResultM.
ForwardBE  output  2  operand B select, same encoding as ForwardAE.
StallF  output  1  hold the PC.
StallD  output  1  hold the F/D register.
StallE  output  1  hold the D/E register.
FlushD  output  1  clear the F/D register.
FlushE  output  1  clear the D/E register.
BubbleM  output  1  load a bubble (all controls 0) into the E/M register.
MultiBusy  output  1  a multi-cycle sequence is in progress.
StallCnt  output  CNT_W  saturating count of cycles with StallF = 1.
FlushCnt  output  CNT_W  saturating count of branch flush cycles.

Behaviour:
Forwarding (combinational):
- ForwardAE = 10 if RegWriteM and RdM != 0 and RdM == RS1E.
- Else ForwardAE = 01 if RegWriteW and RdW != 0 and RdW == RS1E.
- Else ForwardAE = 00.
- ForwardBE uses the same rules with RS2E. The memory stage always has priority over writeback.

Load-use hazard:
- lwStall = ResultSrcE and RdE != 0 and (RdE == RS1D or RdE == RS2D).

Multi-cycle FSM (states IDLE, BUSY; 4-bit down-counter cnt):
- IDLE and MultiE and not PCSrcE: mstall = 1; next state BUSY; cnt <= MULTI_LAT-2.
- BUSY with cnt != 0: mstall = 1; cnt decrements.
- BUSY with cnt == 0: mstall = 0; next state IDLE. The op leaves execute on this edge.
- Total execute occupancy is MULTI_LAT cycles; stalls are asserted for MULTI_LAT-1 cycles.
- MultiBusy = 1 whenever the state is BUSY.
- MultiE is ignored while in BUSY.
- If PCSrcE and MultiE are both 1 in IDLE, the flush wins and no sequence starts.

Output equations:
- StallF = StallD = lwStall | mstall.
- StallE = mstall; BubbleM = mstall.
- FlushD = PCSrcE.
- FlushE = PCSrcE | (lwStall & ~mstall). A load-use bubble must never kill a held multi-cycle op.

Counters:
- StallCnt increments on each falling edge where StallF = 1.
- FlushCnt increments on each falling edge where PCSrcE = 1.
- Both saturate at all-ones.
- CntClr zeroes both counters and has priority over increment.

Reset:
- rst low (asynchronous, any time, including mid-sequence): state IDLE, cnt 0, StallCnt 0, FlushCnt 0.
- During reset, mstall = 0; outputs then follow the combinational equations with mstall = 0.
- A multi-cycle op interrupted by reset is abandoned.

Test Plan:
- Forwarding: RS1E = 5, RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> 01. Set RdM = RdW = 0 with the write enables high -> 00.
- Load-use: ResultSrcE = 1, RdE = 7, RS2D = 7 -> StallF = StallD = FlushE = 1 and StallE = 0 for one cycle. StallCnt goes 0 -> 1.
- Branch: PCSrcE = 1 for one cycle -> FlushD = FlushE = 1, no stall, FlushCnt = 1. PCSrcE and MultiE together in IDLE -> no BUSY entry.
- Multi-cycle with MULTI_LAT = 4: pulse MultiE -> StallF/StallD/StallE/BubbleM high for exactly 3 cycles, MultiBusy high for 3 cycles, then IDLE. With lwStall also true during BUSY, FlushE stays 0.
- Reset during BUSY (cnt = 1): assert rst low -> MultiBusy = 0, stalls drop immediately, both counters read 0. After release, a new MultiE gives a full 3-cycle stall.
- Saturation and clear: preload by running 2^CNT_W + 3 stall cycles -> StallCnt = FFFF. CntClr = 1 together with StallF = 1 -> StallCnt = 0.
